// File: rtl/comparator_pkg.sv
// Shared opcode encodings for the compare stage and the decoder that drives op.
// Optional signed compare is enabled elsewhere via COMPARATOR_SIGNED_EN.
package comparator_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_EQ = 3'b000;
  localparam logic [OP_W-1:0] OP_GE = 3'b001;
  localparam logic [OP_W-1:0] OP_LE = 3'b010;
  localparam logic [OP_W-1:0] OP_GT = 3'b011;
  localparam logic [OP_W-1:0] OP_LT = 3'b100;
  localparam logic [OP_W-1:0] OP_NE = 3'b101;

  // Reserved opcodes (110/111) fall to the default and report false.
  function automatic logic op_select(
    input logic [OP_W-1:0] op,
    input logic            eq,
    input logic            lt,
    input logic            gt
  );
    logic res;
    res = 1'b0;
    case (op)
      OP_EQ:   res = eq;
      OP_GE:   res = eq | gt;
      OP_LE:   res = eq | lt;
      OP_GT:   res = gt;
      OP_LT:   res = lt;
      OP_NE:   res = ~eq;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational magnitude/equality compare of a and b under opcode op.
// COMPARATOR_SIGNED_EN adds signed_mode for two's-complement ordering.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
`ifdef COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             result
);

  logic [WIDTH-1:0] a_ord;
  logic [WIDTH-1:0] b_ord;
  logic             eq;
  logic             lt;
  logic             gt;

  // Inverting both sign bits maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes.
  always_comb begin
    a_ord = a;
    b_ord = b;
`ifdef COMPARATOR_SIGNED_EN
    if (signed_mode) begin
      a_ord[WIDTH-1] = ~a[WIDTH-1];
      b_ord[WIDTH-1] = ~b[WIDTH-1];
    end
`endif
  end

  always_comb begin
    eq     = (a == b);
    lt     = (a_ord < b_ord);
    gt     = (a_ord > b_ord);
    result = op_select(op, eq, lt, gt);
  end

endmodule

// File: rtl/comparator_unit.sv
// Registered compare stage: compout is the comparator_core result one clock late.
// Define COMPARATOR_SIGNED_EN to add the signed_mode port.
module comparator_unit
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
`ifdef COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             compout
);

  logic core_result;
  logic compout_d;
  logic compout_q;

  comparator_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a          (a),
    .b          (b),
    .op         (op),
`ifdef COMPARATOR_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .result     (core_result)
  );

  always_comb begin
    compout_d = core_result;
    if (rst) begin
      compout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    compout_q <= compout_d;
  end

  assign compout = compout_q;

endmodule

// File: tb/tb_comparator_unit.sv
// Self-checking bench for comparator_unit: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_comparator_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         sm;
  logic         compout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  comparator_unit #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .op         (op),
`ifdef COMPARATOR_SIGNED_EN
    .signed_mode(sm),
`endif
    .compout    (compout)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [2:0] o, input logic s);
    longint vx, vy;
    if (s) begin
      vx = $signed(x);
      vy = $signed(y);
    end else begin
      vx = longint'({32'd0, x});
      vy = longint'({32'd0, y});
    end
    case (o)
      3'd0:    return vx == vy;
      3'd1:    return vx >= vy;
      3'd2:    return vx <= vy;
      3'd3:    return vx >  vy;
      3'd4:    return vx <  vy;
      3'd5:    return vx != vy;
      default: return 1'b0;
    endcase
  endfunction

  // Apply inputs away from the edge, then check one edge later.
  task automatic step(input string tag, input logic r, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [2:0] o, input logic s,
                      input logic exp);
    @(negedge clk);
    rst = r; a = x; b = y; op = o; sm = s;
    @(posedge clk);
    #1;
    check(tag, compout, exp);
  endtask

  logic [W-1:0] pa [3];
  logic [2:0]   exp_tab [6];
  logic         e_rand;
  logic [W-1:0] ra, rb;
  logic [2:0]   ro;
  logic         rr, rs;

  initial begin
    rst = 1'b1; a = '0; b = '0; op = 3'd0; sm = 1'b0;

    // Reset for two cycles, then first valid result one edge after release.
    step("rst_cyc0", 1'b1, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    step("rst_cyc1", 1'b1, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    step("rst_release", 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);

    // Each op over (0,0),(0,1),(1,0); expected bits are {r00,r01,r10}.
    exp_tab[0] = 3'b100; exp_tab[1] = 3'b101; exp_tab[2] = 3'b110;
    exp_tab[3] = 3'b001; exp_tab[4] = 3'b010; exp_tab[5] = 3'b011;
    for (int o = 0; o < 6; o++) begin
      logic [2:0] t;
      t = exp_tab[o];
      step($sformatf("op%0d_00", o), 1'b0, 32'd0, 32'd0, 3'(o), 1'b0, t[2]);
      step($sformatf("op%0d_01", o), 1'b0, 32'd0, 32'd1, 3'(o), 1'b0, t[1]);
      step($sformatf("op%0d_10", o), 1'b0, 32'd1, 32'd0, 3'(o), 1'b0, t[0]);
    end

    step("rsvd_110", 1'b0, 32'd5, 32'd5, 3'b110, 1'b0, 1'b0);
    step("rsvd_111", 1'b0, 32'd5, 32'd5, 3'b111, 1'b0, 1'b0);

    step("lt_0_ones_u", 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b1);
`ifdef COMPARATOR_SIGNED_EN
    step("lt_0_ones_s", 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 3'd4, 1'b1, 1'b0);
    step("gt_0_ones_s", 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 3'd3, 1'b1, 1'b1);
    step("eq_ones_s",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b1, 1'b1);
`endif
    step("eq_ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1);
    step("le_0_0",  1'b0, 32'd0, 32'd0, 3'd2, 1'b0, 1'b1);

    // Back-to-back opcode changes on a=7,b=3.
    step("b2b_gt", 1'b0, 32'd7, 32'd3, 3'd3, 1'b0, 1'b1);
    step("b2b_lt", 1'b0, 32'd7, 32'd3, 3'd4, 1'b0, 1'b0);
    step("b2b_eq", 1'b0, 32'd7, 32'd3, 3'd0, 1'b0, 1'b0);

    // Reset mid-stream while the result is high.
    step("mid_pre",  1'b0, 32'd7, 32'd3, 3'd3, 1'b0, 1'b1);
    step("mid_rst",  1'b1, 32'd7, 32'd3, 3'd3, 1'b0, 1'b0);
    step("mid_rec",  1'b0, 32'd7, 32'd3, 3'd3, 1'b0, 1'b1);

    // Randomized traffic, biased toward boundary operands and occasional reset.
    pa[0] = '0; pa[1] = '1; pa[2] = 32'h8000_0000;
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? pa[$urandom_range(0, 2)] : W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = pa[$urandom_range(0, 2)];
        2:       rb = ra + W'($urandom_range(0, 2)) - W'(1);
        default: rb = W'($urandom);
      endcase
      ro = 3'($urandom_range(0, 7));
      rr = ($urandom_range(0, 19) == 0);
`ifdef COMPARATOR_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      e_rand = rr ? 1'b0 : ref_cmp(ra, rb, ro, rs);
      step($sformatf("rand%0d_op%0d", i, ro), rr, ra, rb, ro, rs, e_rand);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
